regfile_port_arbiter: RTL

- Shares the single register-file access port between two requesters: the core control sequencer (port c_*) and the debug/program-load port (port d_*).
- Round-robin arbitration and one transaction in flight at a time.
- Req/gnt/done handshake to each requester; en/done handshake to the register file, matching the register file's done-flag style.
- Sits between the control unit, the debug loader and the register file.

---
 rtl/regfile_port_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares the single register-file access port between
// the core control sequencer (c_*) and the debug/program-load port (d_*).
// Round-robin arbitration, one transaction in flight, req/gnt/done handshake
// to each requester and en/done handshake to the register file.
// Optional feature macro: ARB_TIMEOUT_EN (abort a WAIT that exceeds TIMEOUT
// cycles with done+err). Without it, WAIT persists until rf_done and the
// err outputs stay 0.
module regfile_port_arbiter #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic              c_err,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,

    output logic              rf_en,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic              rf_done,

    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    logic [1:0]        state, state_nxt;
    logic              last, last_nxt;
    logic              owner, owner_nxt;
    logic              lat_we, lat_we_nxt;
    logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
    logic [DATA_W-1:0] lat_wdata, lat_wdata_nxt;
    logic [DATA_W-1:0] c_rdata_nxt, d_rdata_nxt;
    logic              abort_nxt;
    logic              capture;
    logic              win;

    logic              busy_nxt;
    logic              issue_nxt;
    logic              resp_nxt;
    logic              c_gnt_nxt, d_gnt_nxt;
    logic              c_done_nxt, d_done_nxt;
    logic              c_err_nxt, d_err_nxt;
    logic              rf_en_nxt, rf_we_nxt;
    logic [ADDR_W-1:0] rf_addr_nxt;
    logic [DATA_W-1:0] rf_wdata_nxt;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Next-state, arbitration, latching and next-output computation.
    always_comb begin
        state_nxt     = state;
        last_nxt      = last;
        owner_nxt     = owner;
        lat_we_nxt    = lat_we;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        c_rdata_nxt   = c_rdata;
        d_rdata_nxt   = d_rdata;
        abort_nxt     = 1'b0;
        capture       = 1'b0;
        win           = OWN_CORE;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_nxt  = wait_cnt;
`endif

        case (state)
            S_IDLE: begin
                if (c_req || d_req) begin
                    // Tie goes to whoever did not win last time.
                    if (c_req && d_req) begin
                        win = ~last;
                    end else begin
                        win = d_req ? OWN_DBG : OWN_CORE;
                    end
                    owner_nxt = win;
                    last_nxt  = win;
                    state_nxt = S_ISSUE;
                    if (win == OWN_DBG) begin
                        lat_we_nxt    = d_we;
                        lat_addr_nxt  = d_addr;
                        lat_wdata_nxt = d_wdata;
                    end else begin
                        lat_we_nxt    = c_we;
                        lat_addr_nxt  = c_addr;
                        lat_wdata_nxt = c_wdata;
                    end
                end
            end
            S_ISSUE: begin
                if (rf_done) begin
                    state_nxt = S_RESP;
                    capture   = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_nxt = '0;
`endif
                end
            end
            S_WAIT: begin
                if (rf_done) begin
                    state_nxt = S_RESP;
                    capture   = 1'b1;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state_nxt = S_RESP;
                        abort_nxt = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    end
`endif
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Only reads update the owner's rdata; writes and aborts leave it.
        if (capture && !lat_we) begin
            if (owner == OWN_DBG) begin
                d_rdata_nxt = rf_rdata;
            end else begin
                c_rdata_nxt = rf_rdata;
            end
        end

        busy_nxt     = (state_nxt != S_IDLE);
        issue_nxt    = (state_nxt == S_ISSUE);
        resp_nxt     = (state_nxt == S_RESP);
        c_gnt_nxt    = busy_nxt && (owner_nxt == OWN_CORE);
        d_gnt_nxt    = busy_nxt && (owner_nxt == OWN_DBG);
        c_done_nxt   = resp_nxt && (owner_nxt == OWN_CORE);
        d_done_nxt   = resp_nxt && (owner_nxt == OWN_DBG);
        c_err_nxt    = c_done_nxt && abort_nxt;
        d_err_nxt    = d_done_nxt && abort_nxt;
        rf_en_nxt    = issue_nxt;
        rf_we_nxt    = issue_nxt && lat_we_nxt;
        rf_addr_nxt  = issue_nxt ? lat_addr_nxt : '0;
        rf_wdata_nxt = issue_nxt ? lat_wdata_nxt : '0;
    end

    // State, bookkeeping and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            last      <= OWN_DBG;
            owner     <= OWN_CORE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            c_gnt     <= 1'b0;
            c_done    <= 1'b0;
            c_err     <= 1'b0;
            c_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            rf_en     <= 1'b0;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            owner     <= owner_nxt;
            lat_we    <= lat_we_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
            c_gnt     <= c_gnt_nxt;
            c_done    <= c_done_nxt;
            c_err     <= c_err_nxt;
            c_rdata   <= c_rdata_nxt;
            d_gnt     <= d_gnt_nxt;
            d_done    <= d_done_nxt;
            d_err     <= d_err_nxt;
            d_rdata   <= d_rdata_nxt;
            rf_en     <= rf_en_nxt;
            rf_we     <= rf_we_nxt;
            rf_addr   <= rf_addr_nxt;
            rf_wdata  <= rf_wdata_nxt;
            busy      <= busy_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // WAIT-cycle counter for the abort timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end
`endif

endmodule
